// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: bus word, RAM handshake status and memory arbiter states.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE,
    BUSY,
    ACCESS,
    ERROR
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE,
    IACC,
    DACC
  } arb_state_t;

  // Returned to the requester when an access fails or times out.
  localparam word_t BADWORD = 32'hBAD1BAD1;

endpackage

// File: rtl/mem_arbiter.sv
// Shares the single-port unified RAM between fetch and data ports, one access at a time.
// Data has priority; a streak counter forces fetch through, and errors/timeouts set a sticky err.
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int TMO  = 16,
  parameter int MAXD = 4
) (
  input  logic      CLK,
  input  logic      nRST,
  input  logic      iREN,
  input  word_t     iaddr,
  output word_t     iload,
  output logic      iwait,
  input  logic      dREN,
  input  logic      dWEN,
  input  word_t     daddr,
  input  word_t     dstore,
  output word_t     dload,
  output logic      dwait,
  output logic      ramREN,
  output logic      ramWEN,
  output word_t     ramaddr,
  output word_t     ramstore,
  input  word_t     ramload,
  input  ramstate_t ramstate,
  output logic      err
);

  localparam int              TW    = (TMO > 1) ? $clog2(TMO) : 1;
  localparam logic [TW-1:0]   TLAST = TW'(TMO - 1);
  localparam logic [2:0]      DMAX  = 3'(MAXD);

  arb_state_t      state, next_state;
  logic [2:0]      dcnt;
  logic [TW-1:0]   tcnt;
  logic            d_req;
  logic            ram_ok;
  logic            ram_bad;
  logic            done;
  logic            bad;

  // NOTE: every output gets a default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    next_state = state;
    ramREN     = 1'b0;
    ramWEN     = 1'b0;
    ramaddr    = '0;
    ramstore   = '0;
    iload      = '0;
    dload      = '0;
    done       = 1'b0;
    bad        = 1'b0;
    d_req      = dREN | dWEN;
    ram_ok     = (ramstate == ACCESS);
    ram_bad    = (ramstate == ERROR) || ((tcnt == TLAST) && !ram_ok);

    case (state)
      IDLE: begin
        if (d_req && !((dcnt == DMAX) && iREN)) next_state = DACC;
        else if (iREN)                          next_state = IACC;
      end
      IACC: begin
        if (!iREN) begin
          next_state = IDLE;
        end else begin
          ramREN  = 1'b1;
          ramaddr = iaddr;
          if (ram_ok || ram_bad) begin
            done       = 1'b1;
            bad        = ram_bad;
            iload      = ram_bad ? BADWORD : ramload;
            next_state = IDLE;
          end
        end
      end
      DACC: begin
        if (!d_req) begin
          next_state = IDLE;
        end else begin
          ramWEN   = dWEN;
          ramREN   = dREN & ~dWEN;
          ramaddr  = daddr;
          ramstore = dstore;
          if (ram_ok || ram_bad) begin
            done       = 1'b1;
            bad        = ram_bad;
            dload      = ram_bad ? BADWORD : ramload;
            next_state = IDLE;
          end
        end
      end
      default: next_state = IDLE;
    endcase

    iwait = iREN  & ~((state == IACC) && done);
    dwait = d_req & ~((state == DACC) && done);
  end

  // NOTE: registers update with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= IDLE;
      dcnt  <= '0;
      tcnt  <= '0;
      err   <= 1'b0;
    end else begin
      state <= next_state;
      err   <= err | bad;

      if ((state == IDLE) || (next_state == IDLE)) tcnt <= '0;
      else                                         tcnt <= tcnt + 1'b1;

      // Data streak only grows while fetch is actually waiting behind it.
      if ((state == DACC) && done && iREN) begin
        if (dcnt != DMAX) dcnt <= dcnt + 1'b1;
      end else if (((state == IACC) && done) || !iREN) begin
        dcnt <= '0;
      end
    end
  end

endmodule
